multi_seq_hazard_unit: RTL and testbench

- Parametrised successor to the pipeline hazard detector for the 16-bit LM/SM ISA.
- Sits beside the ID stage and watches the ID, RR, EX and MEM pipeline registers.
- Drives the PC hold, the per-stage flush and hold controls, and the IR-load mux.
- Adds a registered LM/SM micro-sequencer FSM with abort, plus valid-qualified hazard checks.

---
 rtl/isa_pkg.sv | 83 ++++++++
 rtl/lm_sm_sequencer.sv | 97 +++++++++
 rtl/multi_seq_hazard_unit.sv | 158 +++++++++++++++
 tb/tb_multi_seq_hazard_unit.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/isa_pkg.sv
// Opcode map, field slicers and destination decode for the 16-bit LM/SM ISA.
// Also holds the micro-sequencer state type shared by the hazard unit.
package isa_pkg;

    localparam int ISA_XLEN   = 16;
    localparam int ISA_REG_W  = 3;
    localparam int ISA_MASK_W = 8;

    typedef logic [3:0]           opcode_t;
    typedef logic [ISA_REG_W-1:0] reg_idx_t;

    // ADD/ADC/ADZ and NDU/NDC/NDZ share an opcode; the CZ bits pick the flavour.
    localparam opcode_t ADD = 4'b0000;
    localparam opcode_t ADC = 4'b0000;
    localparam opcode_t ADZ = 4'b0000;
    localparam opcode_t ADI = 4'b0001;
    localparam opcode_t NDU = 4'b0010;
    localparam opcode_t NDC = 4'b0010;
    localparam opcode_t NDZ = 4'b0010;
    localparam opcode_t LHI = 4'b0011;
    localparam opcode_t LW  = 4'b0100;
    localparam opcode_t SW  = 4'b0101;
    localparam opcode_t LM  = 4'b0110;
    localparam opcode_t SM  = 4'b0111;
    localparam opcode_t JAL = 4'b1000;
    localparam opcode_t JLR = 4'b1001;
    localparam opcode_t BEQ = 4'b1100;

    typedef enum logic {ST_IDLE, ST_SEQ} seq_state_t;

    typedef struct packed {
        logic     valid;
        reg_idx_t idx;
    } reg_wr_t;

    function automatic opcode_t f_opcode(input logic [ISA_XLEN-1:0] ir);
        return ir[15:12];
    endfunction

    function automatic reg_idx_t f_ra(input logic [ISA_XLEN-1:0] ir);
        return ir[11:9];
    endfunction

    function automatic reg_idx_t f_rb(input logic [ISA_XLEN-1:0] ir);
        return ir[8:6];
    endfunction

    function automatic reg_idx_t f_rc(input logic [ISA_XLEN-1:0] ir);
        return ir[5:3];
    endfunction

    function automatic logic is_alu(input opcode_t op);
        return (op == ADD) || (op == ADC) || (op == ADZ) ||
               (op == NDU) || (op == NDC) || (op == NDZ);
    endfunction

    // An LM only names a single destination once it has been split into a one-hot micro-op.
    function automatic reg_wr_t writes_reg(input logic [ISA_XLEN-1:0] ir);
        reg_wr_t                 w;
        logic [ISA_MASK_W-1:0]   m;
        opcode_t                 op;
        w  = '0;
        m  = ir[ISA_MASK_W-1:0];
        op = f_opcode(ir);
        if (is_alu(op)) begin
            w.valid = 1'b1;
            w.idx   = f_rc(ir);
        end else if (op == ADI) begin
            w.valid = 1'b1;
            w.idx   = f_rb(ir);
        end else if ((op == LW) || (op == LHI)) begin
            w.valid = 1'b1;
            w.idx   = f_ra(ir);
        end else if ((op == LM) && (m != '0) && ((m & (m - ISA_MASK_W'(1))) == '0)) begin
            w.valid = 1'b1;
            for (int k = 0; k < ISA_MASK_W; k++) begin
                if (m[k]) w.idx = reg_idx_t'(k);
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/lm_sm_sequencer.sv
// LM/SM micro-sequencer: splits a register mask into one-hot micro-ops, lowest bit first.
// The first micro-op issues straight from the ID mask; later ones come from the remaining-mask register.
module lm_sm_sequencer
    import isa_pkg::*;
#(
    parameter int MASK_W = 8,
    parameter int CNT_W  = $clog2(MASK_W) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_start,
    input  logic              i_abort,
    input  logic              i_freeze,
    input  logic [MASK_W-1:0] i_id_mask,
    output logic              o_busy,
    output logic              o_uop_valid,
    output logic              o_uop_first,
    output logic              o_uop_last,
    output logic              o_more,
    output logic [MASK_W-1:0] o_uop_mask,
    output logic [CNT_W-1:0]  o_uop_offset
);

    seq_state_t        r_state, w_state_nxt;
    logic [MASK_W-1:0] r_mask, w_mask_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic [MASK_W-1:0] w_src, w_onehot, w_rest;

    assign w_src      = (r_state == ST_SEQ) ? r_mask : i_id_mask;
    assign w_onehot   = w_src & (~w_src + MASK_W'(1));
    assign w_rest     = w_src & ~w_onehot;
    assign o_uop_mask = w_onehot;
    assign o_busy     = (r_state == ST_SEQ);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_mask  <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_mask  <= w_mask_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_nxt  = r_state;
        w_mask_nxt   = r_mask;
        w_cnt_nxt    = r_cnt;
        o_uop_valid  = 1'b0;
        o_uop_first  = 1'b0;
        o_uop_last   = 1'b0;
        o_more       = 1'b0;
        o_uop_offset = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    o_uop_valid  = 1'b1;
                    o_uop_first  = 1'b1;
                    o_uop_offset = '0;
                    if (w_rest == '0) begin
                        o_uop_last = 1'b1;
                    end else begin
                        o_more      = 1'b1;
                        w_mask_nxt  = w_rest;
                        w_cnt_nxt   = CNT_W'(1);
                        w_state_nxt = ST_SEQ;
                    end
                end
            end
            ST_SEQ: begin
                if (i_abort) begin
                    w_state_nxt = ST_IDLE;
                    w_mask_nxt  = '0;
                    w_cnt_nxt   = '0;
                end else if (!i_freeze) begin
                    o_uop_valid = 1'b1;
                    if (w_rest == '0) begin
                        o_uop_last  = 1'b1;
                        w_state_nxt = ST_IDLE;
                        w_mask_nxt  = '0;
                        w_cnt_nxt   = '0;
                    end else begin
                        o_more     = 1'b1;
                        w_mask_nxt = w_rest;
                        w_cnt_nxt  = r_cnt + CNT_W'(1);
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

endmodule

// File: rtl/multi_seq_hazard_unit.sv
// Pipeline hazard unit for the LM/SM ISA: prioritised branch, PC-write, load-use and jump
// handling around the LM/SM micro-sequencer. Controls are combinational from inputs and state.
module multi_seq_hazard_unit
    import isa_pkg::*;
#(
    parameter int XLEN   = 16,
    parameter int NREGS  = 8,
    parameter int MASK_W = 8,
    parameter int PC_REG = 7,
    parameter int CNT_W  = $clog2(MASK_W) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [XLEN-1:0]  i_id_ir,
    input  logic             i_id_valid,
    input  logic [XLEN-1:0]  i_rr_ir,
    input  logic [XLEN-1:0]  i_ex_ir,
    input  logic [XLEN-1:0]  i_mem_ir,
    input  logic             i_rr_valid,
    input  logic             i_ex_valid,
    input  logic             i_mem_valid,
    input  logic             i_ex_equ,
    output logic             o_pc_hold,
    output logic             o_if_id_hold,
    output logic             o_flush_if_id,
    output logic             o_flush_id_rr,
    output logic             o_flush_rr_ex,
    output logic             o_uop_sel,
    output logic [XLEN-1:0]  o_uop_ir,
    output logic             o_uop_valid,
    output logic             o_uop_first,
    output logic             o_uop_last,
    output logic [CNT_W-1:0] o_uop_offset,
    output logic             o_seq_busy
);

    localparam int                REG_W  = $clog2(NREGS);
    localparam logic [REG_W-1:0] PC_IDX = REG_W'(PC_REG);

    logic              r_out_en;
    opcode_t           w_id_op, w_rr_op, w_ex_op;
    reg_wr_t           w_id_wr, w_rr_wr, w_ex_wr, w_mem_wr;
    logic              w_p1, w_p2, w_p3, w_p5;
    logic              w_src_a_en, w_src_b_en, w_rr_load, w_id_lmsm;
    logic              w_start, w_busy, w_more;
    logic              w_seq_valid, w_seq_first, w_seq_last;
    logic [MASK_W-1:0] w_seq_mask;
    logic [CNT_W-1:0]  w_seq_offset;

    // Outputs stay quiet after reset release until the first clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_out_en <= 1'b0;
        else        r_out_en <= 1'b1;
    end

    assign w_id_op  = f_opcode(i_id_ir);
    assign w_rr_op  = f_opcode(i_rr_ir);
    assign w_ex_op  = f_opcode(i_ex_ir);
    assign w_id_wr  = writes_reg(i_id_ir);
    assign w_rr_wr  = writes_reg(i_rr_ir);
    assign w_ex_wr  = writes_reg(i_ex_ir);
    assign w_mem_wr = writes_reg(i_mem_ir);

    assign w_p1 = i_ex_valid && (w_ex_op == BEQ) && i_ex_equ;

    // A raw LM in ID is not yet a micro-op, so it is excluded from the PC-writer check.
    assign w_p2 = (i_id_valid  && (w_id_op != LM) && w_id_wr.valid && (w_id_wr.idx == PC_IDX)) ||
                  (i_rr_valid  && w_rr_wr.valid  && (w_rr_wr.idx  == PC_IDX)) ||
                  (i_ex_valid  && w_ex_wr.valid  && (w_ex_wr.idx  == PC_IDX)) ||
                  (i_mem_valid && w_mem_wr.valid && (w_mem_wr.idx == PC_IDX));

    always_comb begin
        w_src_a_en = 1'b0;
        w_src_b_en = 1'b0;
        if (is_alu(w_id_op) || (w_id_op == BEQ)) begin
            w_src_a_en = 1'b1;
            w_src_b_en = 1'b1;
        end else if ((w_id_op == ADI) || (w_id_op == LM) || (w_id_op == SM)) begin
            w_src_a_en = 1'b1;
        end else if ((w_id_op == LW) || (w_id_op == SW)) begin
            w_src_b_en = 1'b1;
        end
    end

    assign w_rr_load = i_rr_valid && ((w_rr_op == LW) || (w_rr_op == LM)) && w_rr_wr.valid;
    assign w_p3      = !w_busy && i_id_valid && w_rr_load &&
                       ((w_src_a_en && (f_ra(i_id_ir) == w_rr_wr.idx)) ||
                        (w_src_b_en && (f_rb(i_id_ir) == w_rr_wr.idx)));

    assign w_id_lmsm = i_id_valid && ((w_id_op == LM) || (w_id_op == SM)) &&
                       (i_id_ir[MASK_W-1:0] != '0);
    assign w_start   = r_out_en && w_id_lmsm && !w_p1 && !w_p2 && !w_p3;

    assign w_p5 = (i_id_valid && ((w_id_op == JAL) || (w_id_op == JLR))) ||
                  (i_rr_valid && (w_rr_op == JLR));

    lm_sm_sequencer #(
        .MASK_W (MASK_W),
        .CNT_W  (CNT_W)
    ) u_seq (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_start      (w_start),
        .i_abort      (r_out_en && w_p1),
        .i_freeze     (r_out_en && w_p2),
        .i_id_mask    (i_id_ir[MASK_W-1:0]),
        .o_busy       (w_busy),
        .o_uop_valid  (w_seq_valid),
        .o_uop_first  (w_seq_first),
        .o_uop_last   (w_seq_last),
        .o_more       (w_more),
        .o_uop_mask   (w_seq_mask),
        .o_uop_offset (w_seq_offset)
    );

    assign o_seq_busy = r_out_en && w_busy;

    always_comb begin
        o_pc_hold     = 1'b0;
        o_if_id_hold  = 1'b0;
        o_flush_if_id = 1'b0;
        o_flush_id_rr = 1'b0;
        o_flush_rr_ex = 1'b0;
        o_uop_sel     = 1'b0;
        o_uop_ir      = '0;
        o_uop_valid   = 1'b0;
        o_uop_first   = 1'b0;
        o_uop_last    = 1'b0;
        o_uop_offset  = '0;
        if (!r_out_en) begin
            o_pc_hold = 1'b0;
        end else if (w_p1) begin
            o_flush_if_id = 1'b1;
            o_flush_id_rr = 1'b1;
            o_flush_rr_ex = 1'b1;
        end else if (w_p2) begin
            o_flush_if_id = 1'b1;
            o_pc_hold     = 1'b1;
        end else if (w_p3) begin
            o_pc_hold     = 1'b1;
            o_if_id_hold  = 1'b1;
            o_flush_id_rr = 1'b1;
        end else if (w_seq_valid) begin
            o_uop_sel    = 1'b1;
            o_uop_valid  = 1'b1;
            o_uop_first  = w_seq_first;
            o_uop_last   = w_seq_last;
            o_uop_ir     = {i_id_ir[XLEN-1:MASK_W], w_seq_mask};
            o_uop_offset = w_seq_offset;
            o_pc_hold    = w_more;
            o_if_id_hold = w_more;
        end else if (w_p5) begin
            o_flush_if_id = 1'b1;
            o_pc_hold     = 1'b1;
        end
    end

endmodule

// File: tb/tb_multi_seq_hazard_unit.sv
// Directed bench for multi_seq_hazard_unit with hand-computed control vectors.
module tb_multi_seq_hazard_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] id_ir, rr_ir, ex_ir, mem_ir;
    logic        id_valid, rr_valid, ex_valid, mem_valid, ex_equ;
    logic        pc_hold, if_id_hold, flush_if_id, flush_id_rr, flush_rr_ex;
    logic        uop_sel, uop_valid, uop_first, uop_last, seq_busy;
    logic [15:0] uop_ir;
    logic [3:0]  uop_offset;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    multi_seq_hazard_unit dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_id_ir       (id_ir),
        .i_id_valid    (id_valid),
        .i_rr_ir       (rr_ir),
        .i_ex_ir       (ex_ir),
        .i_mem_ir      (mem_ir),
        .i_rr_valid    (rr_valid),
        .i_ex_valid    (ex_valid),
        .i_mem_valid   (mem_valid),
        .i_ex_equ      (ex_equ),
        .o_pc_hold     (pc_hold),
        .o_if_id_hold  (if_id_hold),
        .o_flush_if_id (flush_if_id),
        .o_flush_id_rr (flush_id_rr),
        .o_flush_rr_ex (flush_rr_ex),
        .o_uop_sel     (uop_sel),
        .o_uop_ir      (uop_ir),
        .o_uop_valid   (uop_valid),
        .o_uop_first   (uop_first),
        .o_uop_last    (uop_last),
        .o_uop_offset  (uop_offset),
        .o_seq_busy    (seq_busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // {pc_hold, if_id_hold, flush_if_id, flush_id_rr, flush_rr_ex, uop_sel, uop_valid, uop_first, uop_last, seq_busy}
    function automatic logic [9:0] ctl();
        return {pc_hold, if_id_hold, flush_if_id, flush_id_rr, flush_rr_ex,
                uop_sel, uop_valid, uop_first, uop_last, seq_busy};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        id_ir = '0; rr_ir = '0; ex_ir = '0; mem_ir = '0;
        id_valid = 1'b0; rr_valid = 1'b0; ex_valid = 1'b0; mem_valid = 1'b0;
        ex_equ = 1'b0;
    endtask

    initial begin
        idle_all();
        rst_n = 1'b0;
        id_ir = 16'h8000;      // JAL R0
        id_valid = 1'b1;
        #12;
        check("rst_ctl", 32'(ctl()), 32'(10'b00_000_0000_0));
        check("rst_uop_ir", 32'(uop_ir), 32'h0);
        rst_n = 1'b1;
        #2;
        check("rel_gate", 32'(ctl()), 32'(10'b00_000_0000_0));
        tick();
        check("jal_id", 32'(ctl()), 32'(10'b10_100_0000_0));

        // LM R1, mask 1000_0101
        idle_all();
        id_ir = 16'h6285; id_valid = 1'b1;
        #1;
        check("lm_c0_ctl", 32'(ctl()), 32'(10'b11_000_1110_0));
        check("lm_c0_ir", 32'(uop_ir), 32'h6201);
        check("lm_c0_off", 32'(uop_offset), 32'd0);
        tick();
        check("lm_c1_ctl", 32'(ctl()), 32'(10'b11_000_1100_1));
        check("lm_c1_ir", 32'(uop_ir), 32'h6204);
        check("lm_c1_off", 32'(uop_offset), 32'd1);
        tick();
        check("lm_c2_ctl", 32'(ctl()), 32'(10'b00_000_1101_1));
        check("lm_c2_ir", 32'(uop_ir), 32'h6280);
        check("lm_c2_off", 32'(uop_offset), 32'd2);
        tick();
        id_valid = 1'b0;
        #1;
        check("lm_done", 32'(ctl()), 32'(10'b00_000_0000_0));

        // LW R3 in RR, ADD R4,R3,R5 in ID
        idle_all();
        rr_ir = 16'h46C0; rr_valid = 1'b1;
        id_ir = 16'h0760; id_valid = 1'b1;
        #1;
        check("ldu_stall", 32'(ctl()), 32'(10'b11_010_0000_0));
        tick();
        rr_valid = 1'b0;
        #1;
        check("ldu_after", 32'(ctl()), 32'(10'b00_000_0000_0));

        // LM micro-op writing R3 in RR, SW R1,R3 in ID
        idle_all();
        rr_ir = 16'h6008; rr_valid = 1'b1;
        id_ir = 16'h52C0; id_valid = 1'b1;
        #1;
        check("ldu_lmuop", 32'(ctl()), 32'(10'b11_010_0000_0));

        // BEQ taken during SEQ with two bits left
        idle_all();
        id_ir = 16'h640E; id_valid = 1'b1;
        #1;
        check("abort_c0_ir", 32'(uop_ir), 32'h6402);
        tick();
        ex_ir = 16'hC000; ex_valid = 1'b1; ex_equ = 1'b1;
        #1;
        check("abort_ctl", 32'(ctl()), 32'(10'b00_111_0000_1));
        tick();
        idle_all();
        #1;
        check("abort_idle", 32'(ctl()), 32'(10'b00_000_0000_0));

        // ADD R1,R2,R7 walking ID -> RR -> EX -> MEM
        idle_all();
        id_ir = 16'h02B8; id_valid = 1'b1;
        #1;
        check("pcw_id", 32'(ctl()), 32'(10'b10_100_0000_0));
        tick();
        idle_all(); rr_ir = 16'h02B8; rr_valid = 1'b1;
        #1;
        check("pcw_rr", 32'(ctl()), 32'(10'b10_100_0000_0));
        tick();
        idle_all(); ex_ir = 16'h02B8; ex_valid = 1'b1;
        #1;
        check("pcw_ex", 32'(ctl()), 32'(10'b10_100_0000_0));
        tick();
        idle_all(); mem_ir = 16'h02B8; mem_valid = 1'b1;
        #1;
        check("pcw_mem", 32'(ctl()), 32'(10'b10_100_0000_0));
        tick();
        mem_valid = 1'b0;
        #1;
        check("pcw_clear", 32'(ctl()), 32'(10'b00_000_0000_0));
        id_ir = 16'h02B8; id_valid = 1'b0;
        #1;
        check("pcw_invalid", 32'(ctl()), 32'(10'b00_000_0000_0));

        // SM with empty and single-bit masks
        idle_all();
        id_ir = 16'h7200; id_valid = 1'b1;
        #1;
        check("sm_zero", 32'(ctl()), 32'(10'b00_000_0000_0));
        id_ir = 16'h7210;
        #1;
        check("sm_one_ctl", 32'(ctl()), 32'(10'b00_000_1111_0));
        check("sm_one_ir", 32'(uop_ir), 32'h7210);
        check("sm_one_off", 32'(uop_offset), 32'd0);
        tick();
        id_valid = 1'b0;
        #1;
        check("sm_one_busy", 32'(ctl()), 32'(10'b00_000_0000_0));

        // PC write in MEM freezes the sequence
        idle_all();
        id_ir = 16'h6203; id_valid = 1'b1;
        #1;
        check("frz_c0", 32'(ctl()), 32'(10'b11_000_1110_0));
        tick();
        mem_ir = 16'h02B8; mem_valid = 1'b1;
        #1;
        check("frz_hold", 32'(ctl()), 32'(10'b10_100_0000_1));
        tick();
        mem_valid = 1'b0;
        #1;
        check("frz_resume", 32'(ctl()), 32'(10'b00_000_1101_1));
        check("frz_ir", 32'(uop_ir), 32'h6202);
        check("frz_off", 32'(uop_offset), 32'd1);
        tick();

        // Reset pulse mid-sequence
        idle_all();
        id_ir = 16'h6207; id_valid = 1'b1;
        #1;
        tick();
        rst_n = 1'b0;
        #1;
        check("mrst_ctl", 32'(ctl()), 32'(10'b00_000_0000_0));
        check("mrst_ir", 32'(uop_ir), 32'h0);
        tick();
        rst_n = 1'b1;
        #1;
        check("mrst_gate", 32'(ctl()), 32'(10'b00_000_0000_0));
        tick();
        check("mrst_restart", 32'(ctl()), 32'(10'b11_000_1110_0));
        check("mrst_ir0", 32'(uop_ir), 32'h6201);
        check("mrst_off0", 32'(uop_offset), 32'd0);
        tick();
        tick();
        check("mrst_last_ctl", 32'(ctl()), 32'(10'b00_000_1101_1));
        check("mrst_last_off", 32'(uop_offset), 32'd2);
        tick();

        // JLR in RR, valid and invalid
        idle_all();
        rr_ir = 16'h9280; rr_valid = 1'b1;
        #1;
        check("jlr_rr", 32'(ctl()), 32'(10'b10_100_0000_0));
        rr_valid = 1'b0;
        #1;
        check("jlr_rr_inv", 32'(ctl()), 32'(10'b00_000_0000_0));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
